// File: rtl/onchip_mem_loader_pkg.sv
// Shared constants, FSM state encoding and address helpers for the on-chip memory loader.
// The memory is 5120 words deep, so addresses wrap at DEPTH and not at the 13-bit boundary.
package onchip_mem_loader_pkg;

    localparam int DEPTH = 5120;
    localparam int AW    = 13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_VERIFY,
        S_CHECK,
        S_DONE
    } loader_state_t;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
        return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
    endfunction

    // A base above the top of memory folds back once; 8191 - 5120 is still in range.
    function automatic logic [AW-1:0] wrap_base(input logic [AW-1:0] b);
        return (b >= AW'(DEPTH)) ? b - AW'(DEPTH) : b;
    endfunction

endpackage

// File: rtl/onchip_mem_loader_addr_gen.sv
// Word address walker: loads a base and a length, steps with wrap, and flags the last and
// past-the-end indices. It can rewind to the stored base for the readback pass.
module onchip_mem_loader_addr_gen
    import onchip_mem_loader_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          init,
    input  logic          rewind,
    input  logic          step,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   length,
    output logic [AW-1:0] addr,
    output logic          last,
    output logic          full
);

    logic [AW-1:0] base_q;
    logic [AW:0]   len_q;
    logic [AW:0]   cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= '0;
            len_q  <= '0;
            addr   <= '0;
            cnt    <= '0;
        end else if (init) begin
            base_q <= wrap_base(base);
            len_q  <= length;
            addr   <= wrap_base(base);
            cnt    <= '0;
        end else if (rewind) begin
            addr <= base_q;
            cnt  <= '0;
        end else if (step) begin
            addr <= wrap_inc(addr);
            cnt  <= cnt + (AW+1)'(1);
        end
    end

    assign last = (cnt == len_q - (AW+1)'(1));
    assign full = (cnt == len_q);

endmodule

// File: rtl/onchip_mem_loader.sv
// Stream-to-memory loader with optional readback checksum verification.
// Handshake: a word transfers on a rising edge where in_valid and in_ready are both high.
module onchip_mem_loader
    import onchip_mem_loader_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   length,
    input  logic          verify_en,
    input  logic [31:0]   in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [AW-1:0] mem_address,
    output logic [3:0]    mem_byteenable,
    output logic          mem_chipselect,
    output logic          mem_write,
    output logic [31:0]   mem_writedata,
    output logic          mem_clken,
    input  logic [31:0]   mem_readdata,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [31:0]   checksum,
    output loader_state_t dbg_state
);

    loader_state_t state, next_state;
    logic          verify_q;
    logic [31:0]   rb_sum;
    logic          rd_valid;
    logic          gen_init, gen_rewind, gen_step;
    logic [AW-1:0] gen_addr;
    logic          gen_last, gen_full;
    logic          wr_issue, rd_issue;
    logic          len_ok;

    assign len_ok         = (length != '0) && (length <= (AW+1)'(DEPTH));
    assign mem_byteenable = {4{mem_chipselect}};
    assign mem_clken      = 1'b1;
    assign dbg_state      = state;

    onchip_mem_loader_addr_gen u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .init   (gen_init),
        .rewind (gen_rewind),
        .step   (gen_step),
        .base   (base),
        .length (length),
        .addr   (gen_addr),
        .last   (gen_last),
        .full   (gen_full)
    );

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        gen_init   = 1'b0;
        gen_rewind = 1'b0;
        gen_step   = 1'b0;
        wr_issue   = 1'b0;
        rd_issue   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        gen_init   = 1'b1;
                        next_state = S_LOAD;
                    end else begin
                        next_state = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_issue = 1'b1;
                    // Rewinding on the final word puts the base on the walker for the first read.
                    if (gen_last) begin
                        gen_rewind = 1'b1;
                        next_state = S_DRAIN;
                    end else begin
                        gen_step = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (verify_q) begin
                    rd_issue   = 1'b1;
                    gen_step   = 1'b1;
                    next_state = S_VERIFY;
                end else begin
                    next_state = S_DONE;
                end
            end
            S_VERIFY: begin
                if (!gen_full) begin
                    rd_issue = 1'b1;
                    gen_step = 1'b1;
                end else begin
                    next_state = S_CHECK;
                end
            end
            S_CHECK: next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            mem_address    <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            checksum       <= '0;
            verify_q       <= 1'b0;
            rb_sum         <= '0;
            rd_valid       <= 1'b0;
        end else begin
            state          <= next_state;
            mem_chipselect <= wr_issue | rd_issue;
            mem_write      <= wr_issue;
            done           <= (state == S_DONE);
            // Read data returns the cycle after a read strobe is on the bus.
            rd_valid       <= mem_chipselect & ~mem_write;
            if (wr_issue | rd_issue) mem_address <= gen_addr;
            if (wr_issue) begin
                mem_writedata <= in_data;
                checksum      <= checksum + in_data;
            end
            if (rd_valid) rb_sum <= rb_sum + mem_readdata;
            if (state == S_CHECK) error <= ((rb_sum + mem_readdata) != checksum);
            if (state == S_IDLE && start) begin
                busy     <= 1'b1;
                verify_q <= verify_en;
                if (len_ok) begin
                    checksum <= '0;
                    error    <= 1'b0;
                    rb_sum   <= '0;
                end else begin
                    error <= 1'b1;
                end
            end else if (state == S_DONE) begin
                busy <= 1'b0;
            end
        end
    end

endmodule
